// File: rtl/parity_frame_chk.sv
// Streaming per-word and per-frame parity checker with saturating error count.
// Optional err_sticky output when PARITY_ERR_STICKY_EN is defined.
module parity_frame_chk #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode,
  input  logic             clr_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
`ifdef PARITY_ERR_STICKY_EN
  output logic             err_sticky,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic             mode_q;
  logic             acc_x_q;
  logic             acc_e_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_par_q;
  logic             out_err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  logic accept;
  logic mode_eff;
  logic word_x;
  logic word_err;
  logic cnt_sat;

  assign accept   = in_valid & in_ready_q;
  assign mode_eff = (state_q == IDLE) ? odd_mode : mode_q;
  assign word_x   = ^in_data;
  assign word_err = accept & (in_par != (word_x ^ mode_eff));
  assign cnt_sat  = &err_cnt_q;

  // Clear wins over the old count, but a coincident bad word still counts.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt)
      err_cnt_d = word_err ? CNT_W'(1) : '0;
    else if (word_err && !cnt_sat)
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      acc_x_q     <= 1'b0;
      acc_e_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q <= odd_mode;
            if (in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_par_q   <= word_x ^ odd_mode;
              out_err_q   <= word_err;
            end else begin
              state_q <= ACCUM;
              acc_x_q <= word_x;
              acc_e_q <= word_err;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_par_q   <= acc_x_q ^ word_x ^ mode_q;
              out_err_q   <= acc_e_q | word_err;
            end else begin
              acc_x_q <= acc_x_q ^ word_x;
              acc_e_q <= acc_e_q | word_err;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_x_q     <= 1'b0;
            acc_e_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          acc_x_q     <= 1'b0;
          acc_e_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_ERR_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sticky_q <= 1'b0;
    else if ((state_q == HOLD) && out_ready && out_err_q)
      sticky_q <= 1'b1;
    else if (clr_cnt)
      sticky_q <= 1'b0;
  end

  assign err_sticky = sticky_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_chk.sv
// Directed table-driven bench for parity_frame_chk (WIDTH=8, CNT_W=2).
// Multi-cycle corners (hold, saturation, reset) are hand-written sequences.
module tb_parity_frame_chk;

  logic       clk = 1'b0;
  logic       rst;
  logic       odd_mode;
  logic       clr_cnt;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_par;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic       out_par;
  logic       out_err;
  logic [1:0] err_cnt;
`ifdef PARITY_ERR_STICKY_EN
  logic       err_sticky;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parity_frame_chk #(.WIDTH(8), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .odd_mode  (odd_mode),
    .clr_cnt   (clr_cnt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_par   (out_par),
    .out_err   (out_err),
`ifdef PARITY_ERR_STICKY_EN
    .err_sticky(err_sticky),
`endif
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic       odd;
    logic [7:0] data;
    logic       par;
    logic       last;
    logic       e_par;
    logic       e_err;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic odd, input logic [7:0] d,
                      input logic p, input logic l);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    odd_mode = odd;
    in_data  = d;
    in_par   = p;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[4] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[5] = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[6] = '{1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};

    rst = 1'b1;
    odd_mode = 0; clr_cnt = 0; in_valid = 0;
    in_data = 0; in_par = 0; in_last = 0; out_ready = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_par", out_par, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].odd, tbl[i].data, tbl[i].par, tbl[i].last);
      chk($sformatf("v%0d_cnt", i), err_cnt, tbl[i].e_cnt);
      if (tbl[i].last) begin
        chk($sformatf("v%0d_valid", i), out_valid, 1);
        chk($sformatf("v%0d_par", i), out_par, tbl[i].e_par);
        chk($sformatf("v%0d_err", i), out_err, tbl[i].e_err);
        chk($sformatf("v%0d_inrdy", i), in_ready, 0);
        drain();
      end else begin
        chk($sformatf("v%0d_novalid", i), out_valid, 0);
      end
    end

    // Backpressure: result held, words offered but refused.
    send(1'b1, 8'h03, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_par   = 1'b1;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_inrdy", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_par", out_par, 1);
      chk("hold_err", out_err, 0);
    end
    chk("hold_cnt", err_cnt, 2);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("hold_rel_valid", out_valid, 0);
    chk("hold_rel_inrdy", in_ready, 1);
    @(negedge clk);
    chk("hold_no_accept", out_valid, 0);

    // Saturation: six bad words in one frame, count 2 -> 3 and stays.
    for (int k = 0; k < 6; k++)
      send(1'b0, 8'h01, 1'b0, (k == 5));
    chk("sat_cnt", err_cnt, 3);
    chk("sat_err", out_err, 1);
    chk("sat_par", out_par, 0);
`ifdef PARITY_ERR_STICKY_EN
    chk("sticky_pre", err_sticky, 1);
`endif
    drain();
    clr_cnt = 1'b1;
    send(1'b0, 8'h01, 1'b0, 1'b1);
    clr_cnt = 1'b0;
    chk("clr_bad_cnt", err_cnt, 1);
    drain();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_only_cnt", err_cnt, 0);
`ifdef PARITY_ERR_STICKY_EN
    chk("sticky_clr", err_sticky, 0);
`endif

    // Reset mid-frame discards partial state.
    send(1'b1, 8'h01, 1'b1, 1'b0);
    send(1'b1, 8'h03, 1'b0, 1'b0);
    chk("pre_rst_cnt", err_cnt, 2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    chk("mid_rst_inrdy", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_novalid", out_valid, 0);
    send(1'b1, 8'h80, 1'b0, 1'b1);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_par", out_par, 0);
    chk("post_rst_err", out_err, 0);
    chk("post_rst_cnt", err_cnt, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
